// File: rtl/systolic_pe.sv
// Output-stationary systolic PE: forwards A east / B south, accumulates a dot
// product under valid/last framing, and drains results via a capture/shift chain.
// Optional SATURATE_EN: clamp accumulation to the signed/unsigned range and flag ovf.
module systolic_pe #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic                 valid_in,
  input  logic                 last_in,
  input  logic                 signed_in,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic                 valid_out,
  output logic                 last_out,
  output logic                 signed_out,
  input  logic                 capture_in,
  input  logic                 shift_en,
  input  logic [ACC_WIDTH-1:0] c_in,
  output logic [ACC_WIDTH-1:0] c_out,
  output logic                 done,
  output logic                 ovf
);

  generate
    if (ACC_WIDTH < 2 * WIDTH) begin : g_bad_width
      $error("systolic_pe: ACC_WIDTH must be >= 2*WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

  state_t               state_r, state_next_s;
  logic [ACC_WIDTH-1:0] acc_r;
  logic [ACC_WIDTH-1:0] a_ext_s, b_ext_s, prod_s, base_s, sum_s, next_acc_s;
  logic                 clamp_s, accept_s, clear_s;

  // Operand extension; the truncated ACC_WIDTH product equals the extended full product.
  always_comb begin
    a_ext_s = {ACC_WIDTH{1'b0}};
    b_ext_s = {ACC_WIDTH{1'b0}};
    if (signed_in) begin
      a_ext_s = ACC_WIDTH'($signed(a_in));
      b_ext_s = ACC_WIDTH'($signed(b_in));
    end else begin
      a_ext_s = ACC_WIDTH'(a_in);
      b_ext_s = ACC_WIDTH'(b_in);
    end
  end

  assign prod_s = a_ext_s * b_ext_s;
  assign base_s = (state_r == ACC) ? acc_r : {ACC_WIDTH{1'b0}};
  assign sum_s  = base_s + prod_s;

`ifdef SATURATE_EN
  logic [ACC_WIDTH:0] usum_s;
  assign usum_s = {1'b0, base_s} + {1'b0, prod_s};

  // Clamp detection: signed uses same-sign-in/different-sign-out, unsigned uses carry.
  always_comb begin
    clamp_s    = 1'b0;
    next_acc_s = sum_s;
    if (signed_in) begin
      if ((base_s[ACC_WIDTH-1] == prod_s[ACC_WIDTH-1]) &&
          (sum_s[ACC_WIDTH-1] != base_s[ACC_WIDTH-1])) begin
        clamp_s    = 1'b1;
        next_acc_s = base_s[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        clamp_s    = 1'b0;
        next_acc_s = sum_s;
      end
    end else begin
      if (usum_s[ACC_WIDTH]) begin
        clamp_s    = 1'b1;
        next_acc_s = {ACC_WIDTH{1'b1}};
      end else begin
        clamp_s    = 1'b0;
        next_acc_s = sum_s;
      end
    end
  end
`else
  assign clamp_s    = 1'b0;
  assign next_acc_s = sum_s;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // FSM next-state logic; DONE is left only by a capture.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (valid_in) state_next_s = last_in ? DONE : ACC;
        else          state_next_s = IDLE;
      end
      ACC: begin
        if (valid_in) state_next_s = last_in ? DONE : ACC;
        else          state_next_s = ACC;
      end
      DONE: begin
        if (capture_in) state_next_s = IDLE;
        else            state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: accept a pair outside DONE, clear the accumulator on capture out of DONE.
  always_comb begin
    accept_s = 1'b0;
    clear_s  = 1'b0;
    case (state_r)
      IDLE, ACC: begin
        accept_s = valid_in;
        clear_s  = 1'b0;
      end
      DONE: begin
        accept_s = 1'b0;
        clear_s  = capture_in;
      end
      default: begin
        accept_s = 1'b0;
        clear_s  = 1'b0;
      end
    endcase
  end

  // Accumulator, sticky overflow and registered done decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= {ACC_WIDTH{1'b0}};
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= (state_next_s == DONE);
      if (clear_s) begin
        acc_r <= {ACC_WIDTH{1'b0}};
        ovf   <= 1'b0;
      end else if (accept_s) begin
        acc_r <= next_acc_s;
        ovf   <= ovf | clamp_s;
      end else begin
        acc_r <= acc_r;
        ovf   <= ovf;
      end
    end
  end

  // Drain register: capture beats shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             c_out <= {ACC_WIDTH{1'b0}};
    else if (capture_in) c_out <= acc_r;
    else if (shift_en)   c_out <= c_in;
    else                 c_out <= c_out;
  end

  // Operand and framing forwarding, independent of FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out      <= {WIDTH{1'b0}};
      b_out      <= {WIDTH{1'b0}};
      valid_out  <= 1'b0;
      last_out   <= 1'b0;
      signed_out <= 1'b0;
    end else begin
      a_out      <= a_in;
      b_out      <= b_in;
      valid_out  <= valid_in;
      last_out   <= last_in;
      signed_out <= signed_in;
    end
  end

endmodule

// File: tb/tb_systolic_pe.sv
// Directed bench: a 3-PE drain chain (u2 is the tail under test) plus a
// 16-bit-accumulator PE for the wrap/saturation case.
module tb_systolic_pe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  a_drv [3];
  logic [7:0]  b_drv;
  logic        valid, last, sgn, cap, sh;
  logic [7:0]  a_o [4];
  logic [7:0]  b_o [4];
  logic        v_o [4];
  logic        l_o [4];
  logic        s_o [4];
  logic [31:0] c_o [3];
  logic [15:0] c16;
  logic        done_o [4];
  logic        ovf_o [4];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  systolic_pe #(.WIDTH(8), .ACC_WIDTH(32)) u0 (
    .clk(clk), .rst(rst), .a_in(a_drv[0]), .b_in(b_drv), .valid_in(valid), .last_in(last),
    .signed_in(sgn), .a_out(a_o[0]), .b_out(b_o[0]), .valid_out(v_o[0]), .last_out(l_o[0]),
    .signed_out(s_o[0]), .capture_in(cap), .shift_en(sh), .c_in(32'd0), .c_out(c_o[0]),
    .done(done_o[0]), .ovf(ovf_o[0]));
  systolic_pe #(.WIDTH(8), .ACC_WIDTH(32)) u1 (
    .clk(clk), .rst(rst), .a_in(a_drv[1]), .b_in(b_drv), .valid_in(valid), .last_in(last),
    .signed_in(sgn), .a_out(a_o[1]), .b_out(b_o[1]), .valid_out(v_o[1]), .last_out(l_o[1]),
    .signed_out(s_o[1]), .capture_in(cap), .shift_en(sh), .c_in(c_o[0]), .c_out(c_o[1]),
    .done(done_o[1]), .ovf(ovf_o[1]));
  systolic_pe #(.WIDTH(8), .ACC_WIDTH(32)) u2 (
    .clk(clk), .rst(rst), .a_in(a_drv[2]), .b_in(b_drv), .valid_in(valid), .last_in(last),
    .signed_in(sgn), .a_out(a_o[2]), .b_out(b_o[2]), .valid_out(v_o[2]), .last_out(l_o[2]),
    .signed_out(s_o[2]), .capture_in(cap), .shift_en(sh), .c_in(c_o[1]), .c_out(c_o[2]),
    .done(done_o[2]), .ovf(ovf_o[2]));
  systolic_pe #(.WIDTH(8), .ACC_WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .a_in(a_drv[2]), .b_in(b_drv), .valid_in(valid), .last_in(last),
    .signed_in(sgn), .a_out(a_o[3]), .b_out(b_o[3]), .valid_out(v_o[3]), .last_out(l_o[3]),
    .signed_out(s_o[3]), .capture_in(cap), .shift_en(sh), .c_in(16'd0), .c_out(c16),
    .done(done_o[3]), .ovf(ovf_o[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic v, input logic l,
                       input logic s, input logic c, input logic h);
    a_drv[0] = a; a_drv[1] = a; a_drv[2] = a;
    b_drv = b; valid = v; last = l; sgn = s; cap = c; sh = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;
    #1;
    chk("rst_c_out", c_o[2], 32'd0);
    chk("rst_done", {31'd0, done_o[2]}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_o[2]}, 32'd0);
    chk("rst_a_out", {24'd0, a_o[2]}, 32'd0);

    // Unsigned dot product: 12 + 30 + 65025
    drive(8'd3, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("fwd_a", {24'd0, a_o[2]}, 32'd3);
    chk("fwd_b", {24'd0, b_o[2]}, 32'd4);
    chk("fwd_valid", {31'd0, v_o[2]}, 32'd1);
    chk("acc_not_done", {31'd0, done_o[2]}, 32'd0);
    drive(8'd5, 8'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(8'd255, 8'd255, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("u_done", {31'd0, done_o[2]}, 32'd1);
    chk("fwd_last", {31'd0, l_o[2]}, 32'd1);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk("u_result", c_o[2], 32'd65067);
    chk("u_idle", {31'd0, done_o[2]}, 32'd0);

    // Signed dot product: -6 + (-16256)
    drive(8'hFE, 8'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk("fwd_signed", {31'd0, s_o[2]}, 32'd1);
    drive(8'd127, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    chk("s_done", {31'd0, done_o[2]}, 32'd1);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk("s_result", c_o[2], 32'hFFFFC07A);

    // Capture + valid (+ shift) in ACC: snapshot 7, accumulate to 9
    drive(8'd7, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(8'd2, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    chk("snap_c_out", c_o[2], 32'd7);
    chk("snap_not_done", {31'd0, done_o[2]}, 32'd0);
    drive(8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk("snap_acc", c_o[2], 32'd9);

    // valid in DONE is ignored but forwarded
    drive(8'd1, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(8'd50, 8'd50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("done_fwd_a", {24'd0, a_o[2]}, 32'd50);
    chk("done_hold", {31'd0, done_o[2]}, 32'd1);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk("done_ignore", c_o[2], 32'd1);

    // Drain chain: u0=10, u1=20, u2=30
    drive(8'd0, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    a_drv[0] = 8'd10; a_drv[1] = 8'd20; a_drv[2] = 8'd30;
    tick();
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk("drain_0", c_o[2], 32'd30);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    chk("drain_1", c_o[2], 32'd20);
    tick();
    chk("drain_2", c_o[2], 32'd10);
    tick();
    chk("drain_3", c_o[2], 32'd0);

    // Asynchronous reset mid-ACC, with a non-zero snapshot on c_out
    drive(8'd5, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(8'd5, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk("pre_rst_snap", c_o[2], 32'd25);
    #2 rst = 1'b1;
    #1;
    chk("arst_c_out", c_o[2], 32'd0);
    chk("arst_a_out", {24'd0, a_o[2]}, 32'd0);
    chk("arst_done", {31'd0, done_o[2]}, 32'd0);
    #2 rst = 1'b0;
    drive(8'd2, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("post_rst_done", {31'd0, done_o[2]}, 32'd1);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk("post_rst_result", c_o[2], 32'd4);

    // 16-bit accumulator: 65025 + 65025 overflows
    drive(8'd255, 8'd255, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("w16_first_ovf", {31'd0, ovf_o[3]}, 32'd0);
    drive(8'd255, 8'd255, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
`ifdef SATURATE_EN
    chk("w16_ovf", {31'd0, ovf_o[3]}, 32'd1);
`else
    chk("w16_ovf", {31'd0, ovf_o[3]}, 32'd0);
`endif
    chk("w32_no_ovf", {31'd0, ovf_o[2]}, 32'd0);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
`ifdef SATURATE_EN
    chk("w16_result", {16'd0, c16}, 32'd65535);
`else
    chk("w16_result", {16'd0, c16}, 32'd64514);
`endif
    chk("w16_ovf_cleared", {31'd0, ovf_o[3]}, 32'd0);
    chk("w32_result", c_o[2], 32'd130050);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
